// File: rtl/cim_ctrl_if.sv
// Handshake and register-bus bundle between the CIM controller and its surroundings.
// master = controller side, slave = FIFOs, CIM array and register host.
interface cim_ctrl_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_ADDR       = 4
);
    logic                      reg_en;
    logic [REG_ADDR-1:0]       a_reg;
    logic [REG_DATA_WIDTH-1:0] d_reg;
    logic [REG_DATA_WIDTH-1:0] rd_data;

    logic                      in_empty;
    logic                      in_rd_en;
    logic [DATA_WIDTH-1:0]     in_data;

    logic                      cal_b;
    logic                      cal_done;
    logic [DATA_WIDTH-1:0]     cim_q;
    logic [DATA_WIDTH-1:0]     cim_d;
    logic                      col_en;

    logic                      out_full;
    logic                      out_wr_en;
    logic [DATA_WIDTH-1:0]     out_data;

    logic                      busy;
    logic                      err_timeout;

    modport master (
        input  reg_en, a_reg, d_reg, in_empty, in_data, cal_done, cim_q, out_full,
        output rd_data, in_rd_en, cal_b, cim_d, col_en, out_wr_en, out_data, busy, err_timeout
    );

    modport slave (
        output reg_en, a_reg, d_reg, in_empty, in_data, cal_done, cim_q, out_full,
        input  rd_data, in_rd_en, cal_b, cim_d, col_en, out_wr_en, out_data, busy, err_timeout
    );
endinterface

// File: rtl/cim_ctrl_pipe.sv
// CIM macro controller: pops a word, runs the CIM compute handshake with timeout,
// post-processes per lane (shift, offset, saturate) and pushes the result out.
module cim_ctrl_pipe #(
    parameter int DATA_WIDTH     = 64,
    parameter int LANE_WIDTH     = 16,
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_ADDR       = 4,
    parameter int TO_WIDTH       = 16
) (
    input  logic       clk,
    input  logic       rst,
    cim_ctrl_if.master bus
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int N_OFF = (LANES + 1) / 2;
    localparam int OFF_W = 16;
    localparam int SUM_W = ((LANE_WIDTH > OFF_W) ? LANE_WIDTH : OFF_W) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (LANE_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [3:0] {IDLE, FETCH, LOAD, CAL, PROC, OUT, DONE, ERR, STALL} state_t;

    state_t                    state, state_nxt, saved;
    logic                      ctrl_start, ctrl_clr, col_en;
    logic [3:0]                shift;
    logic [REG_DATA_WIDTH-1:0] off_reg [N_OFF];
    logic [15:0]               batch, word_cnt;
    logic [TO_WIDTH-1:0]       timeout, to_cnt;
    logic [DATA_WIDTH-1:0]     cim_d, cim_res, out_data, proc_word;
    logic [REG_DATA_WIDTH-1:0] rd;
    logic                      in_rd_en, out_wr_en, pop_q, start_accept;
    logic                      cfg_wr, stall_req, busy;

    // Offset registers: lanes 0-3 at 0x2/0x3, further lane pairs from 0xB upward.
    function automatic logic [REG_ADDR-1:0] off_addr(input int k);
        return REG_ADDR'(k < 2 ? 2 + k : 9 + k);
    endfunction

    function automatic logic [LANE_WIDTH-1:0] post(input logic [LANE_WIDTH-1:0] x,
                                                   input logic [3:0]            sh,
                                                   input logic [OFF_W-1:0]      off);
        logic signed [LANE_WIDTH-1:0] xs;
        logic signed [SUM_W-1:0]      sum;
        logic [LANE_WIDTH-1:0]        res;
        xs  = $signed(x) >>> sh;
        sum = $signed({{(SUM_W-LANE_WIDTH){xs[LANE_WIDTH-1]}}, xs})
            + $signed({{(SUM_W-OFF_W){off[OFF_W-1]}}, off});
        if (sum > SAT_MAX)      res = SAT_MAX[LANE_WIDTH-1:0];
        else if (sum < SAT_MIN) res = SAT_MIN[LANE_WIDTH-1:0];
        else                    res = sum[LANE_WIDTH-1:0];
        return res;
    endfunction

    assign cfg_wr    = bus.reg_en && bus.a_reg >= REG_ADDR'(1) && bus.a_reg <= REG_ADDR'(5);
    assign stall_req = cfg_wr && (state inside {FETCH, LOAD, CAL, PROC, OUT});
    assign busy      = !(state inside {IDLE, DONE, ERR});

    // NOTE: the offset array holds configuration, so it is reset like every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_start <= 1'b0;
            ctrl_clr   <= 1'b0;
            col_en     <= 1'b0;
            shift      <= '0;
            batch      <= '0;
            timeout    <= '0;
            for (int k = 0; k < N_OFF; k++) off_reg[k] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            ctrl_start <= 1'b0;
            ctrl_clr   <= 1'b0;
            if (bus.reg_en) begin
                case (bus.a_reg)
                    REG_ADDR'(0): begin
                        ctrl_start <= bus.d_reg[0];
                        ctrl_clr   <= bus.d_reg[1];
                        col_en     <= bus.d_reg[31];
                    end
                    REG_ADDR'(1): shift   <= bus.d_reg[3:0];
                    REG_ADDR'(4): batch   <= bus.d_reg[15:0];
                    REG_ADDR'(5): timeout <= bus.d_reg[TO_WIDTH-1:0];
                    default: ;
                endcase
                for (int k = 0; k < N_OFF; k++)
                    if (bus.a_reg == off_addr(k)) off_reg[k] <= bus.d_reg;
            end
        end
    end

    always_comb begin
        rd = '0;
        case (bus.a_reg)
            REG_ADDR'(0): rd[31] = col_en;
            REG_ADDR'(1): rd[3:0] = shift;
            REG_ADDR'(4): rd[15:0] = batch;
            REG_ADDR'(5): rd[TO_WIDTH-1:0] = timeout;
            REG_ADDR'(6): begin
                rd[0]     = busy;
                rd[1]     = (state == DONE);
                rd[2]     = (state == ERR);
                rd[3]     = (state == STALL);
                rd[31:16] = word_cnt;
            end
            default: ;
        endcase
        for (int k = 0; k < N_OFF; k++)
            if (bus.a_reg == off_addr(k)) rd = off_reg[k];
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        in_rd_en     = 1'b0;
        out_wr_en    = 1'b0;
        start_accept = 1'b0;
        if (ctrl_clr) begin
            state_nxt = IDLE;
        end else if (stall_req) begin
            state_nxt = STALL;
        end else begin
            case (state)
                IDLE, DONE: if (ctrl_start) begin
                    start_accept = 1'b1;
                    state_nxt    = FETCH;
                end
                FETCH: if (!bus.in_empty && !bus.out_full) begin
                    in_rd_en  = 1'b1;
                    state_nxt = LOAD;
                end
                LOAD: state_nxt = CAL;
                CAL: begin
                    if (bus.cal_done)
                        state_nxt = PROC;
                    else if (timeout != '0 && to_cnt == timeout - TO_WIDTH'(1))
                        state_nxt = ERR;
                end
                PROC: state_nxt = OUT;
                OUT: if (!bus.out_full) begin
                    out_wr_en = 1'b1;
                    state_nxt = (batch != '0 && word_cnt + 16'd1 == batch) ? DONE : FETCH;
                end
                STALL: if (!bus.reg_en) state_nxt = saved;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            saved <= IDLE;
        end else begin
            state <= state_nxt;
            if (stall_req) saved <= state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_q    <= 1'b0;
            cim_d    <= '0;
            cim_res  <= '0;
            out_data <= '0;
            to_cnt   <= '0;
            word_cnt <= '0;
        end else begin
            pop_q <= in_rd_en;
            // The popped word appears one cycle later; a stall in LOAD must not reload it.
            if (pop_q) cim_d <= bus.in_data;
            if (state == LOAD)     to_cnt <= '0;
            else if (state == CAL) to_cnt <= to_cnt + TO_WIDTH'(1);
            if (state == CAL && state_nxt == PROC) cim_res <= bus.cim_q;
            if (state == PROC) out_data <= proc_word;
            if (start_accept)   word_cnt <= '0;
            else if (out_wr_en) word_cnt <= word_cnt + 16'd1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign proc_word[i*LANE_WIDTH +: LANE_WIDTH] =
            post(cim_res[i*LANE_WIDTH +: LANE_WIDTH], shift, off_reg[i/2][(i%2)*OFF_W +: OFF_W]);
    end

    assign bus.rd_data     = rd;
    assign bus.in_rd_en    = in_rd_en;
    assign bus.out_wr_en   = out_wr_en;
    assign bus.cal_b       = (state == CAL) || (state == STALL && saved == CAL);
    assign bus.cim_d       = cim_d;
    assign bus.out_data    = out_data;
    assign bus.col_en      = col_en;
    assign bus.busy        = busy;
    assign bus.err_timeout = (state == ERR);
endmodule

// File: tb/tb_cim_ctrl_pipe.sv
// Scoreboard bench for cim_ctrl_pipe: directed vectors push expected words, a
// negedge monitor pops and compares every output FIFO push.
module tb_cim_ctrl_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cim_ctrl_if #(.DATA_WIDTH(64), .REG_DATA_WIDTH(32), .REG_ADDR(4)) bus();

    cim_ctrl_pipe #(
        .DATA_WIDTH(64), .LANE_WIDTH(16), .REG_DATA_WIDTH(32), .REG_ADDR(4), .TO_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          push_cnt = 0;
    logic [63:0] exp_q[$];

    logic [63:0] in_mem [32];
    int          wr_ptr     = 0;
    int          rd_ptr     = 0;
    logic        gate_empty = 1'b0;
    logic        toggle_en  = 1'b0;
    logic        cim_en     = 1'b1;
    int          cal_cnt    = 0;
    int          cal_lat    = 5;

    // Input FIFO: data shows up the cycle after a pop. CIM: answers cim_q = cim_d after cal_lat waits.
    assign bus.in_empty = (rd_ptr == wr_ptr) || gate_empty;
    assign bus.cal_done = cim_en && bus.cal_b && (cal_cnt >= cal_lat);
    assign bus.cim_q    = bus.cim_d;

    always @(posedge clk) begin
        if (bus.in_rd_en) begin
            bus.in_data <= in_mem[rd_ptr[4:0]];
            rd_ptr      <= rd_ptr + 1;
        end
        cal_cnt <= bus.cal_b ? cal_cnt + 1 : 0;
    end

    always @(negedge clk) gate_empty <= toggle_en && !gate_empty;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_wr_en) begin
                push_cnt++;
                check("push_not_full", 64'(bus.out_full), 64'd0);
                check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
            end
            if (bus.in_rd_en) check("pop_legal", 64'(bus.in_empty || bus.out_full), 64'd0);
        end
    end

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        bus.reg_en = 1'b1;
        bus.a_reg  = a;
        bus.d_reg  = d;
        @(negedge clk);
        bus.reg_en = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
        bus.a_reg = a;
        #1;
        check(name, 64'(bus.rd_data), 64'(exp));
    endtask

    task automatic push_word(input logic [63:0] w, input logic [63:0] e, input bit expect_out);
        in_mem[wr_ptr[4:0]] = w;
        wr_ptr++;
        if (expect_out) exp_q.push_back(e);
    endtask

    task automatic wait_run(input string name, input int budget);
        int t = 0;
        while (!bus.busy && t < budget) begin @(negedge clk); t++; end
        while (bus.busy && t < budget)  begin @(negedge clk); t++; end
        check({name, "_finish"}, 64'(t < budget), 64'd1);
    endtask

    task automatic wait_cal_b(input string name, input logic level);
        int t = 0;
        while (bus.cal_b != level && t < 60) begin @(negedge clk); t++; end
        check({name, "_cal_b"}, 64'(bus.cal_b), 64'(level));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int t;
        bus.reg_en   = 1'b0;
        bus.a_reg    = '0;
        bus.d_reg    = '0;
        bus.out_full = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ctl_outs", 64'({bus.in_rd_en, bus.cal_b, bus.out_wr_en, bus.busy,
                                   bus.err_timeout, bus.col_en}), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_cim_d", bus.cim_d, 64'd0);
        rd_check("rst_status", 4'h6, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single word pass-through, BATCH=1
        reg_wr(4'h4, 32'd1);
        rd_check("t1_batch_rb", 4'h4, 32'd1);
        cal_lat = 5;
        push_word(64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 1'b1);
        p0 = push_cnt;
        reg_wr(4'h0, 32'h1);
        wait_run("t1", 100);
        check("t1_pushes", 64'(push_cnt - p0), 64'd1);
        rd_check("t1_status", 4'h6, 32'h0001_0002);

        // Shift, offsets, saturation in both directions
        reg_wr(4'h1, 32'd2);
        reg_wr(4'h2, 32'h0001_7FF0);
        reg_wr(4'h3, 32'h8000_FFFF);
        rd_check("t2_off_lo_rb", 4'h2, 32'h0001_7FF0);
        cal_lat = 2;
        push_word(64'h8004_8000_FFF8_7FFC, 64'h8000_DFFF_FFFF_7FFF, 1'b1);
        p0 = push_cnt;
        reg_wr(4'h0, 32'h1);
        wait_run("t2", 100);
        check("t2_pushes", 64'(push_cnt - p0), 64'd1);
        rd_check("t2_status", 4'h6, 32'h0001_0002);

        // BATCH=3 with toggling in_empty and out_full held at first OUT
        reg_wr(4'h1, 32'd0);
        reg_wr(4'h2, 32'd0);
        reg_wr(4'h3, 32'd0);
        reg_wr(4'h4, 32'd3);
        push_word(64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 1'b1);
        push_word(64'h5555_6666_7777_0001, 64'h5555_6666_7777_0001, 1'b1);
        push_word(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1);
        toggle_en = 1'b1;
        p0 = push_cnt;
        reg_wr(4'h0, 32'h1);
        wait_cal_b("t3", 1'b1);
        bus.out_full = 1'b1;
        repeat (10) @(negedge clk);
        check("t3_held_while_full", 64'(push_cnt - p0), 64'd0);
        bus.out_full = 1'b0;
        wait_run("t3", 400);
        toggle_en = 1'b0;
        check("t3_pushes", 64'(push_cnt - p0), 64'd3);
        check("t3_all_popped", 64'(wr_ptr - rd_ptr), 64'd0);
        rd_check("t3_status", 4'h6, 32'h0003_0002);

        // Cal timeout, then soft_clear
        reg_wr(4'h5, 32'd8);
        reg_wr(4'h4, 32'd1);
        cim_en = 1'b0;
        push_word(64'hDEAD_BEEF_0000_0001, 64'h0, 1'b0);
        reg_wr(4'h0, 32'h1);
        wait_cal_b("t4", 1'b1);
        t = 0;
        while (!bus.err_timeout && t < 40) begin @(negedge clk); t++; end
        check("t4_err_latency", 64'(t), 64'd8);
        check("t4_cal_b_low", 64'(bus.cal_b), 64'd0);
        check("t4_not_busy", 64'(bus.busy), 64'd0);
        rd_check("t4_status_err", 4'h6, 32'h0000_0004);
        reg_wr(4'h0, 32'h2);
        @(negedge clk);
        check("t4_err_cleared", 64'(bus.err_timeout), 64'd0);
        rd_check("t4_status_idle", 4'h6, 32'h0);
        reg_wr(4'h5, 32'd0);
        cim_en = 1'b1;

        // SHIFT write in the same cycle as cal_done: STALL, then resume with the new shift
        reg_wr(4'h0, 32'h8000_0000);
        check("t5_col_en", 64'(bus.col_en), 64'd1);
        cal_lat = 3;
        push_word(64'h0040_0030_0020_0010, 64'h0004_0003_0002_0001, 1'b1);
        p0 = push_cnt;
        reg_wr(4'h0, 32'h8000_0001);
        t = 0;
        while (!bus.cal_done && t < 60) begin @(negedge clk); t++; end
        check("t5_cal_done_seen", 64'(bus.cal_done), 64'd1);
        bus.reg_en = 1'b1;
        bus.a_reg  = 4'h1;
        bus.d_reg  = 32'd4;
        @(negedge clk);
        check("t5_no_push_a", 64'(bus.out_wr_en), 64'd0);
        check("t5_cal_b_held", 64'(bus.cal_b), 64'd1);
        check("t5_shift_applied", 64'(bus.rd_data), 64'd4);
        bus.a_reg = 4'h6;
        #1;
        check("t5_status_stall", 64'(bus.rd_data), 64'h0000_0009);
        @(negedge clk);
        check("t5_no_push_b", 64'(bus.out_wr_en), 64'd0);
        bus.reg_en = 1'b0;
        wait_run("t5", 100);
        check("t5_pushes", 64'(push_cnt - p0), 64'd1);
        rd_check("t5_status", 4'h6, 32'h0001_0002);

        // Asynchronous reset while parked in OUT with out_full=1
        push_word(64'h0100_0200_0300_0400, 64'h0, 1'b0);
        p0 = push_cnt;
        reg_wr(4'h0, 32'h8000_0001);
        wait_cal_b("t6_rise", 1'b1);
        bus.out_full = 1'b1;
        wait_cal_b("t6_fall", 1'b0);
        repeat (2) @(negedge clk);
        check("t6_busy_in_out", 64'(bus.busy), 64'd1);
        check("t6_out_data_pre", bus.out_data, 64'h0010_0020_0030_0040);
        bus.a_reg = 4'h4;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_ctl_outs", 64'({bus.in_rd_en, bus.cal_b, bus.out_wr_en, bus.busy,
                                      bus.err_timeout, bus.col_en}), 64'd0);
        check("t6_rst_out_data", bus.out_data, 64'd0);
        check("t6_rst_cim_d", bus.cim_d, 64'd0);
        check("t6_rst_batch", 64'(bus.rd_data), 64'd0);
        rd_check("t6_rst_ctrl", 4'h0, 32'h0);
        rd_check("t6_rst_shift", 4'h1, 32'h0);
        @(negedge clk);
        rst          = 1'b0;
        bus.out_full = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_idle_after", 64'(bus.busy), 64'd0);
        check("t6_no_late_push", 64'(push_cnt - p0), 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
